data_stream_chk: RTL and testbench
==================================

DATA_STREAM_CHK -- requirements
Module: data_stream_chk

Interface
REQ-001 Parameter STREAM_LEN, default 8: expected pattern length in bits, >=2.
REQ-002 Parameter BIT_STREAM [STREAM_LEN-1:0], default 8'b10101010: expected pattern; bit STREAM_LEN-1 arrives first.
REQ-003 Parameter HOLD_CYCLES, default 10: clock cycles per received bit, >=1.
REQ-004 Parameter LOSS_ERRS, default 2: bit errors within one frame that force loss of lock, >=1.
REQ-005 Parameter ERR_CNT_W, default 16: error counter width.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 clear_in  input  1  synchronous clear: err_count to 0, state to HUNT.
REQ-009 data_in  input  1  serial stream, clk-synchronous, each bit held HOLD_CYCLES cycles.
REQ-010 locked  output  1  high while in LOCKED.
REQ-011 frame_ok  output  1  one-cycle pulse per error-free complete frame, including the lock frame.
REQ-012 bit_err  output  1  one-cycle pulse per mismatched sampled bit while LOCKED.
REQ-013 err_count  output  ERR_CNT_W  saturating count of bit_err pulses.

Function
REQ-014 data_in SHALL be registered once (d1) and again (d2); edge = d1 XOR d2.
REQ-015 Phase counter 0..HOLD_CYCLES-1 SHALL increment each cycle, wrap to 0 after HOLD_CYCLES-1, and load 0 on any edge, overriding increment and wrap, in both states.
REQ-016 Sample strobe SHALL fire in cycles where phase == floor(HOLD_CYCLES/2); sampled bit = d1 that cycle.
REQ-017 HUNT: each sample SHALL shift into a STREAM_LEN shift register (new bit at LSB); fill counter SHALL saturate at STREAM_LEN.
REQ-018 HUNT->LOCKED SHALL occur on the strobe where, after the shift, fill == STREAM_LEN and shift register == BIT_STREAM; bit index set to 0; frame_ok pulses next cycle.
REQ-019 LOCKED: each sample SHALL be compared with BIT_STREAM[STREAM_LEN-1-index]; index increments per strobe, wraps STREAM_LEN-1 -> 0.
REQ-020 Mismatch SHALL pulse bit_err the cycle after the strobe and increment err_count and the per-frame error counter.
REQ-021 err_count SHALL saturate at all-ones and hold; bit_err still pulses.
REQ-022 On the strobe with index == STREAM_LEN-1, frame_ok SHALL pulse next cycle if that frame had zero errors; the per-frame error counter then clears.
REQ-023 When the per-frame error counter reaches LOSS_ERRS: LOCKED->HUNT; shift register, fill and index cleared; locked low next cycle; frame_ok not pulsed even if on a frame boundary.
REQ-024 clear_in SHALL take priority over a simultaneous bit error: err_count 0 next cycle, no increment.
REQ-025 clear_in SHALL force HUNT, clear shift register, fill, index and per-frame errors; locked low next cycle; phase counter unaffected.
REQ-026 A stream stopped on a constant level (single-shot source) SHALL be treated as normal data: mismatches count, lock lost per REQ-023.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 While reset is high, the next edge SHALL set locked, frame_ok, bit_err = 0, err_count = 0, state HUNT, phase, fill, index, shift register, per-frame errors, d1, d2 = 0.
REQ-029 Reset mid-operation SHALL behave as REQ-028, pending pulses dropped; reset overrides clear_in.

Verification
REQ-030 Generator (8'b10101010, HOLD 10, loop) -> checker defaults: locked=1 within 9*10+4 cycles of reset release; frame_ok every 80 cycles; err_count stays 0.
REQ-031 Pattern 8'b11010010, HOLD 1, looping: lock after 8 samples; one injected flipped bit -> exactly one bit_err, err_count=1, no frame_ok for that frame, lock held.
REQ-032 Two flipped bits in one frame, LOSS_ERRS=2 -> err_count=2, locked=0 one cycle after second bit_err's strobe; relock on next clean pattern.
REQ-033 ERR_CNT_W=3, constant-0 input after lock with repeated relock forcing -> err_count sticks at 7; clear_in with simultaneous bit_err -> err_count=0, locked=0.
REQ-034 Single-shot source stops after one frame -> frame_ok once, then bit_err on each mismatched sample until loss of lock; assert reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/data_stream_chk.sv
// Serial pattern checker: hunts for BIT_STREAM in a held-bit serial stream, then
// tracks lock, clean frames, bit errors and a saturating error count.
module data_stream_chk #(
  parameter int                    STREAM_LEN  = 8,
  parameter logic [STREAM_LEN-1:0] BIT_STREAM  = 8'b10101010,
  parameter int                    HOLD_CYCLES = 10,
  parameter int                    LOSS_ERRS   = 2,
  parameter int                    ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_in,
  input  logic                 data_in,
  output logic                 locked,
  output logic                 frame_ok,
  output logic                 bit_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int PH_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDX_W  = $clog2(STREAM_LEN);
  localparam int FILL_W = $clog2(STREAM_LEN + 1);
  localparam int FE_W   = $clog2(LOSS_ERRS + 1);

  localparam logic [PH_W-1:0]      PH_LAST  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]      PH_MID   = PH_W'(HOLD_CYCLES / 2);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(STREAM_LEN - 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(STREAM_LEN);
  localparam logic [FE_W-1:0]      FE_LOSS  = FE_W'(LOSS_ERRS);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic                  d1_r;
  logic                  d2_r;
  logic                  edge_s;
  logic [PH_W-1:0]       phase_r;
  logic [PH_W-1:0]       phase_nxt_s;
  logic                  strobe_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [STREAM_LEN-1:0] shift_r;
  logic [STREAM_LEN-1:0] shift_nxt_s;
  logic [STREAM_LEN-1:0] shifted_s;
  logic [FILL_W-1:0]     fill_r;
  logic [FILL_W-1:0]     fill_nxt_s;
  logic [FILL_W-1:0]     fill_inc_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [FE_W-1:0]       ferr_r;
  logic [FE_W-1:0]       ferr_nxt_s;
  logic [FE_W-1:0]       ferr_inc_s;
  logic [ERR_CNT_W-1:0]  err_count_r;
  logic [ERR_CNT_W-1:0]  cnt_nxt_s;
  logic                  exp_bit_s;
  logic                  mismatch_s;
  logic                  locked_r;
  logic                  frame_ok_r;
  logic                  frame_ok_nxt_s;
  logic                  bit_err_r;
  logic                  bit_err_nxt_s;

  // Bit-timing recovery: a data edge realigns the phase so sampling lands mid-bit.
  always_comb begin
    edge_s = d1_r ^ d2_r;
    if (edge_s) begin
      phase_nxt_s = {PH_W{1'b0}};
    end else if (phase_r == PH_LAST) begin
      phase_nxt_s = {PH_W{1'b0}};
    end else begin
      phase_nxt_s = phase_r + PH_W'(1);
    end
    strobe_s = (phase_r == PH_MID);
  end

  // Input synchroniser stages and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1_r    <= 1'b0;
      d2_r    <= 1'b0;
      phase_r <= {PH_W{1'b0}};
    end else begin
      d1_r    <= data_in;
      d2_r    <= d1_r;
      phase_r <= phase_nxt_s;
    end
  end

  // Hunt/lock state machine with frame and error bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    fill_nxt_s     = fill_r;
    idx_nxt_s      = idx_r;
    ferr_nxt_s     = ferr_r;
    cnt_nxt_s      = err_count_r;
    frame_ok_nxt_s = 1'b0;
    bit_err_nxt_s  = 1'b0;
    shifted_s      = {shift_r[STREAM_LEN-2:0], d1_r};
    fill_inc_s     = (fill_r == FILL_MAX) ? fill_r : fill_r + FILL_W'(1);
    exp_bit_s      = BIT_STREAM[IDX_LAST - idx_r];
    mismatch_s     = d1_r ^ exp_bit_s;
    ferr_inc_s     = ferr_r + FE_W'(mismatch_s);

    if (clear_in) begin
      state_nxt_s = ST_HUNT;
      shift_nxt_s = {STREAM_LEN{1'b0}};
      fill_nxt_s  = {FILL_W{1'b0}};
      idx_nxt_s   = {IDX_W{1'b0}};
      ferr_nxt_s  = {FE_W{1'b0}};
      cnt_nxt_s   = {ERR_CNT_W{1'b0}};
    end else if (strobe_s) begin
      case (state_r)
        ST_HUNT: begin
          shift_nxt_s = shifted_s;
          fill_nxt_s  = fill_inc_s;
          if ((fill_inc_s == FILL_MAX) && (shifted_s == BIT_STREAM)) begin
            state_nxt_s    = ST_LOCKED;
            idx_nxt_s      = {IDX_W{1'b0}};
            ferr_nxt_s     = {FE_W{1'b0}};
            frame_ok_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          bit_err_nxt_s = mismatch_s;
          if (mismatch_s && (err_count_r != CNT_MAX)) begin
            cnt_nxt_s = err_count_r + ERR_CNT_W'(1);
          end else begin
            cnt_nxt_s = err_count_r;
          end
          // Loss of lock wins over a frame boundary, so no frame_ok then.
          if (ferr_inc_s == FE_LOSS) begin
            state_nxt_s = ST_HUNT;
            shift_nxt_s = {STREAM_LEN{1'b0}};
            fill_nxt_s  = {FILL_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
            ferr_nxt_s  = {FE_W{1'b0}};
          end else if (idx_r == IDX_LAST) begin
            idx_nxt_s      = {IDX_W{1'b0}};
            ferr_nxt_s     = {FE_W{1'b0}};
            frame_ok_nxt_s = (ferr_inc_s == {FE_W{1'b0}});
          end else begin
            idx_nxt_s  = idx_r + IDX_W'(1);
            ferr_nxt_s = ferr_inc_s;
          end
        end
        default: begin
          state_nxt_s = ST_HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_HUNT;
      shift_r     <= {STREAM_LEN{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      ferr_r      <= {FE_W{1'b0}};
      err_count_r <= {ERR_CNT_W{1'b0}};
      locked_r    <= 1'b0;
      frame_ok_r  <= 1'b0;
      bit_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      fill_r      <= fill_nxt_s;
      idx_r       <= idx_nxt_s;
      ferr_r      <= ferr_nxt_s;
      err_count_r <= cnt_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKED);
      frame_ok_r  <= frame_ok_nxt_s;
      bit_err_r   <= bit_err_nxt_s;
    end
  end

  assign locked    = locked_r;
  assign frame_ok  = frame_ok_r;
  assign bit_err   = bit_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_data_stream_chk.sv
// Directed bench for data_stream_chk: default instance fed by a looping generator,
// plus a HOLD_CYCLES=1 / 3-bit-counter instance driven bit by bit.
module tb_data_stream_chk;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_a;
  logic        clear_a;
  logic        locked_a;
  logic        frame_ok_a;
  logic        bit_err_a;
  logic [15:0] err_count_a;
  logic        data_b;
  logic        clear_b;
  logic        locked_b;
  logic        frame_ok_b;
  logic        bit_err_b;
  logic [2:0]  err_count_b;

  logic        gen_a_go = 1'b0;
  logic [7:0]  pat_b = 8'b11010010;

  int n_checks = 0;
  int n_fail = 0;
  int obs_b;
  int nb_err;
  int nb_fok;
  int first_lock;
  logic last_err_locked;
  int cyc;
  int a_err_pulses;

  always #5 clk = ~clk;

  data_stream_chk u_a (
    .clk       (clk),
    .reset     (reset),
    .clear_in  (clear_a),
    .data_in   (data_a),
    .locked    (locked_a),
    .frame_ok  (frame_ok_a),
    .bit_err   (bit_err_a),
    .err_count (err_count_a)
  );

  data_stream_chk #(
    .STREAM_LEN  (8),
    .BIT_STREAM  (8'b11010010),
    .HOLD_CYCLES (1),
    .LOSS_ERRS   (2),
    .ERR_CNT_W   (3)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .clear_in  (clear_b),
    .data_in   (data_b),
    .locked    (locked_b),
    .frame_ok  (frame_ok_b),
    .bit_err   (bit_err_b),
    .err_count (err_count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Looping 10101010 source, each bit held 10 cycles.
  initial begin : gen_a
    logic [7:0] pat;
    pat    = 8'b10101010;
    data_a = 1'b0;
    wait (gen_a_go);
    forever begin
      for (int i = 7; i >= 0; i--) begin
        data_a = pat[i];
        repeat (10) @(posedge clk);
        #1;
      end
    end
  end

  task automatic step_b(input logic b, input logic clr);
    data_b  = b;
    clear_b = clr;
    @(posedge clk);
    #1;
    obs_b++;
    if (bit_err_b) begin
      nb_err++;
      last_err_locked = locked_b;
    end
    if (frame_ok_b) nb_fok++;
    if (locked_b && (first_lock == 0)) first_lock = obs_b;
  endtask

  task automatic send_frame_b(input logic [7:0] flip);
    for (int i = 7; i >= 0; i--) step_b(pat_b[i] ^ flip[i], 1'b0);
  endtask

  task automatic reset_b();
    reset   = 1'b1;
    data_b  = 1'b0;
    clear_b = 1'b0;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    obs_b           = 0;
    nb_err          = 0;
    nb_fok          = 0;
    first_lock      = 0;
    last_err_locked = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    clear_a = 1'b0;
    clear_b = 1'b0;
    data_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_locked", locked_a, 1'b0);
    check_eq("rst_a_frame_ok", frame_ok_a, 1'b0);
    check_eq("rst_a_bit_err", bit_err_a, 1'b0);
    check_eq("rst_a_err_count", err_count_a, 16'd0);
    check_eq("rst_b_locked", locked_b, 1'b0);
    check_eq("rst_b_frame_ok", frame_ok_b, 1'b0);
    check_eq("rst_b_bit_err", bit_err_b, 1'b0);
    check_eq("rst_b_err_count", err_count_b, 3'd0);

    // Default instance: lock time, frame_ok cadence, no errors.
    reset    = 1'b0;
    gen_a_go = 1'b1;
    cyc      = 0;
    while (!locked_a && (cyc < 200)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("a_lock_by_94", (locked_a && (cyc <= 94)), 1'b1);
    check_eq("a_lock_frame_ok", frame_ok_a, 1'b1);
    a_err_pulses = 0;
    for (int f = 0; f < 3; f++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
        if (bit_err_a) a_err_pulses++;
      end while (!frame_ok_a && (cyc < 200));
      check_eq("a_frame_period", cyc, 80);
    end
    check_eq("a_err_pulses", a_err_pulses, 0);
    check_eq("a_err_count", err_count_a, 16'd0);
    check_eq("a_still_locked", locked_a, 1'b1);

    // One flipped bit: one bit_err, frame_ok withheld for that frame, lock held.
    reset_b();
    send_frame_b(8'b00000000);
    send_frame_b(8'b00000000);
    send_frame_b(8'b00010000);
    send_frame_b(8'b00000000);
    step_b(1'b1, 1'b0);
    check_eq("b1_lock_step", first_lock, 9);
    check_eq("b1_frame_oks", nb_fok, 3);
    check_eq("b1_bit_errs", nb_err, 1);
    check_eq("b1_err_count", err_count_b, 3'd1);
    check_eq("b1_locked", locked_b, 1'b1);

    // Two flips in one frame: lock lost with the second bit_err, relock later.
    reset_b();
    send_frame_b(8'b00000000);
    send_frame_b(8'b00100100);
    send_frame_b(8'b00000000);
    send_frame_b(8'b00000000);
    step_b(1'b1, 1'b0);
    check_eq("b2_locked_at_2nd_err", last_err_locked, 1'b0);
    check_eq("b2_bit_errs", nb_err, 2);
    check_eq("b2_err_count", err_count_b, 3'd2);
    check_eq("b2_frame_oks", nb_fok, 3);
    check_eq("b2_relocked", locked_b, 1'b1);

    // Repeated relock then zeros: counter saturates at 7; clear beats a bit error.
    reset_b();
    for (int r = 0; r < 5; r++) begin
      send_frame_b(8'b00000000);
      repeat (3) step_b(1'b0, 1'b0);
    end
    send_frame_b(8'b00000000);
    step_b(1'b0, 1'b0);
    check_eq("b3_bit_errs", nb_err, 10);
    check_eq("b3_err_sat", err_count_b, 3'd7);
    check_eq("b3_locked_pre_clear", locked_b, 1'b1);
    step_b(1'b1, 1'b1);
    check_eq("b3_clear_err_count", err_count_b, 3'd0);
    check_eq("b3_clear_locked", locked_b, 1'b0);
    step_b(1'b0, 1'b0);

    // Single-shot source, then a reset landing on a pending bit_err.
    reset_b();
    send_frame_b(8'b00000000);
    repeat (10) step_b(1'b0, 1'b0);
    check_eq("b4_frame_oks", nb_fok, 1);
    check_eq("b4_bit_errs", nb_err, 2);
    check_eq("b4_locked", locked_b, 1'b0);
    check_eq("b4_err_count", err_count_b, 3'd2);
    reset_b();
    send_frame_b(8'b00000000);
    step_b(1'b1, 1'b0);
    step_b(1'b0, 1'b0);
    check_eq("b4_locked_pre_rst", locked_b, 1'b1);
    reset = 1'b1;
    step_b(1'b1, 1'b0);
    check_eq("b4_rst_locked", locked_b, 1'b0);
    check_eq("b4_rst_frame_ok", frame_ok_b, 1'b0);
    check_eq("b4_rst_bit_err", bit_err_b, 1'b0);
    check_eq("b4_rst_err_count", err_count_b, 3'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
